// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch/sequencing for the 16-bit CPU: owns the PC,
// fetches over a req/valid handshake and computes the next PC on retirement.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_valid,
   input  logic [15:0] imem_rdata,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [3:0]  opcode,
   output logic [3:0]  funct,
   output logic [15:0] pc,
   input  logic        exec_done,
   input  logic        branch,
   input  logic        jump,
   input  logic        alu_zero,
   output logic        halted,
   output logic        fetch_err,
   output logic [2:0]  dbg_state
);

   // Handshake: imem_req is a one-cycle pulse with imem_addr; the response is
   // accepted only while waiting (imem_valid with imem_rdata in the same cycle).
   // instr_valid holds until the cycle in which exec_done is sampled high.
   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_WAIT  = 3'd1,
      S_ISSUE = 3'd2,
      S_HALT  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);
   localparam logic [3:0]  C_OP_BEQ  = 4'b0100;
   localparam logic [3:0]  C_OP_BNE  = 4'b0101;
   localparam logic [3:0]  C_OP_HALT = 4'b1111;

   state_t      r_state;
   logic [15:0] r_pc;
   logic [15:0] r_instr;
   logic [15:0] r_cnt;
   logic        r_live;
   logic        r_instr_valid;
   logic        r_halted;
   logic        r_fetch_err;

   logic [15:0] w_seq_pc;
   logic [15:0] w_br_pc;
   logic [15:0] w_jmp_pc;
   logic [15:0] w_next_pc;
   logic        w_taken;

   assign w_seq_pc = r_pc + 16'd1;
   assign w_br_pc  = w_seq_pc + {{12{r_instr[3]}}, r_instr[3:0]};
   assign w_jmp_pc = {r_pc[15:12], r_instr[11:0]};
   assign w_taken  = branch && (((r_instr[15:12] == C_OP_BEQ) && alu_zero) ||
                                ((r_instr[15:12] == C_OP_BNE) && !alu_zero));

   always_comb begin
      w_next_pc = w_seq_pc;
      if (jump)
         w_next_pc = w_jmp_pc;
      else if (w_taken)
         w_next_pc = w_br_pc;
   end

   // r_live keeps the request low while reset is held and for the first
   // FETCH cycle after release, so a reset-time FETCH never issues a pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_instr       <= 16'h0000;
         r_cnt         <= 16'h0000;
         r_live        <= 1'b0;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
         r_fetch_err   <= 1'b0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            S_FETCH: begin
               r_cnt <= 16'h0000;
               if (r_live)
                  r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_valid) begin
                  r_instr       <= imem_rdata;
                  r_instr_valid <= 1'b1;
                  r_state       <= S_ISSUE;
               end else if (r_cnt == C_TO_LAST) begin
                  r_fetch_err <= 1'b1;
                  r_state     <= S_ERROR;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_ISSUE: begin
               if (exec_done) begin
                  r_instr_valid <= 1'b0;
                  if (r_instr[15:12] == C_OP_HALT) begin
                     r_halted <= 1'b1;
                     r_state  <= S_HALT;
                  end else begin
                     r_pc    <= w_next_pc;
                     r_state <= S_FETCH;
                  end
               end
            end
            S_HALT:  r_state <= S_HALT;
            S_ERROR: r_state <= S_ERROR;
            default: r_state <= S_ERROR;
         endcase
      end
   end

   assign imem_req    = (r_state == S_FETCH) && r_live;
   assign imem_addr   = r_pc;
   assign instr_valid = r_instr_valid;
   assign instr       = r_instr;
   assign opcode      = r_instr[15:12];
   assign funct       = r_instr[3:0];
   assign pc          = r_pc;
   assign halted      = r_halted;
   assign fetch_err   = r_fetch_err;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: drives memory/datapath, keeps a transaction-level
// model of PC and instruction flow, and compares the DUT on every negedge.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic        instr_valid;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [3:0]  funct;
   logic [15:0] pc;
   logic        exec_done = 1'b0;
   logic        branch = 1'b0;
   logic        jump = 1'b0;
   logic        alu_zero = 1'b0;
   logic        halted;
   logic        fetch_err;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .funct(funct),
      .pc(pc), .exec_done(exec_done), .branch(branch), .jump(jump),
      .alu_zero(alu_zero), .halted(halted), .fetch_err(fetch_err),
      .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   logic [15:0] m_pc = 16'h0000;
   logic [15:0] m_instr = 16'h0000;
   bit          m_iv = 1'b0;
   bit          m_halted = 1'b0;
   bit          m_err = 1'b0;
   bit          m_req_ok = 1'b0;
   bit          m_on = 1'b0;
   int          m_nreq = 0;
   int          used = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_next(input logic [15:0] cur, input logic [15:0] ins,
                                              input bit br, input bit jp, input bit z);
      int op;
      int off;
      op  = int'(ins[15:12]);
      off = int'(ins[3:0]);
      if (off > 7) off = off - 16;
      if (jp) return (cur & 16'hF000) | (ins & 16'h0FFF);
      if (br && ((op == 4 && z) || (op == 5 && !z)))
         return 16'((int'(cur) + 1 + off) & 32'h0000FFFF);
      return 16'((int'(cur) + 1) % 65536);
   endfunction

   always @(negedge clk) begin
      if (m_on) begin
         chk("instr_valid", instr_valid, m_iv);
         chk("halted", halted, m_halted);
         chk("fetch_err", fetch_err, m_err);
         if (!m_req_ok)
            chk("imem_req_unexpected", imem_req, 1'b0);
         if (imem_req) begin
            chk("imem_addr", imem_addr, m_pc);
            m_req_ok = 1'b0;
            m_nreq++;
         end
         if (m_iv) begin
            chk("instr", instr, m_instr);
            chk("pc", pc, m_pc);
            chk("opcode", opcode, m_instr[15:12]);
            chk("funct", funct, m_instr[3:0]);
         end
         if (m_halted)
            chk("halt_pc", pc, m_pc);
      end
   end

   task automatic model_reset();
      m_iv     = 1'b0;
      m_halted = 1'b0;
      m_err    = 1'b0;
      m_pc     = 16'h0000;
      m_req_ok = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      used = m_nreq;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (m_nreq != used) begin
            used = m_nreq;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_req: got no request expected one within 30 cycles at %0t", $time);
      end
   endtask

   task automatic do_instr(input logic [15:0] word, input int lat, input int hold,
                           input bit br, input bit jp, input bit z, input bit stray);
      bit ok;
      int rec;
      wait_req(ok);
      if (!ok) return;
      repeat (lat - 1) @(posedge clk);
      @(posedge clk);
      #1 imem_valid = 1'b1;
      imem_rdata = word;
      @(posedge clk);
      #1 imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      m_iv = 1'b1;
      m_instr = word;
      for (int h = 0; h < hold; h++) begin
         imem_valid = stray;
         imem_rdata = 16'($urandom);
         branch = 1'($urandom);
         jump = 1'($urandom);
         alu_zero = 1'($urandom);
         @(posedge clk);
         #1 imem_valid = 1'b0;
      end
      exec_done = 1'b1;
      branch = br;
      jump = jp;
      alu_zero = z;
      @(posedge clk);
      #1 exec_done = 1'b0;
      branch = 1'b0;
      jump = 1'b0;
      alu_zero = 1'b0;
      m_iv = 1'b0;
      if (word[15:12] == 4'hF) begin
         m_halted = 1'b1;
      end else begin
         m_pc = model_next(m_pc, word, br, jp, z);
         m_req_ok = 1'b1;
         rec = m_nreq;
         @(negedge clk);
         #1 chk("req_after_retire", m_nreq, rec + 1);
      end
   endtask

   task automatic pin(input string name, input logic [15:0] exp);
      chk({name, "_model"}, m_pc, exp);
      chk({name, "_addr"}, imem_addr, exp);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      bit ok;
      logic [15:0] w;
      logic [3:0]  op;
      rst_n = 1'b0;
      m_on = 1'b1;
      do_reset();
      @(negedge clk);
      #1 chk("reset_dbg_state", dbg_state, 3'd0);

      // directed sequence
      do_instr(16'h6005, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      pin("jump_to_5", 16'h0005);
      do_instr(16'h0123, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
      pin("seq_5_to_6", 16'h0006);
      do_instr(16'h6010, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      do_instr(16'h4F3E, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      pin("beq_taken", 16'h000F);
      do_instr(16'h6010, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      do_instr(16'h4F3E, 3, 2, 1'b1, 1'b0, 1'b0, 1'b1);
      pin("beq_not_taken", 16'h0011);
      do_instr(16'h6010, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      do_instr(16'h5003, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      pin("bne_taken", 16'h0014);
      do_instr(16'h4F3E, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
      pin("jump_over_branch", 16'h0F3E);
      do_instr(16'h6000, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      do_instr(16'h400E, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      pin("branch_wrap", 16'hFFFF);
      do_instr(16'h6ABC, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      pin("jump_keeps_page", 16'hFABC);
      do_instr(16'h6FFF, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      do_instr(16'h0123, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      pin("seq_wrap", 16'h0000);

      // randomized instruction stream
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 14));
         if ($urandom_range(0, 2) == 0) op = 4'(4 + $urandom_range(0, 1));
         w = {op, 12'($urandom)};
         do_instr(w, $urandom_range(1, 3), $urandom_range(0, 2),
                  1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
      end

      // halt: no requests, stray inputs ignored
      do_instr(16'hF000, 1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      repeat (50) @(posedge clk);
      #1 chk("halted_lit", halted, 1'b1);
      imem_valid = 1'b1;
      imem_rdata = 16'h1234;
      exec_done = 1'b1;
      jump = 1'b1;
      @(posedge clk);
      #1 imem_valid = 1'b0;
      exec_done = 1'b0;
      jump = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("halt_state", dbg_state, 3'd3);

      // timeout: memory never answers
      do_reset();
      wait_req(ok);
      repeat (17) @(posedge clk);
      #1 m_err = 1'b1;
      repeat (30) @(posedge clk);
      #1 chk("fetch_err_lit", fetch_err, 1'b1);
      chk("error_state", dbg_state, 3'd4);

      // asynchronous reset mid-cycle
      #2 rst_n = 1'b0;
      model_reset();
      #1 chk("async_rst_err", fetch_err, 1'b0);
      chk("async_rst_state", dbg_state, 3'd0);
      chk("async_rst_req", imem_req, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      used = m_nreq;

      // reset during WAIT, then a late response that must be ignored
      wait_req(ok);
      @(posedge clk);
      #1 chk("in_wait", dbg_state, 3'd1);
      rst_n = 1'b0;
      model_reset();
      #1 chk("rst_mid_wait_state", dbg_state, 3'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      used = m_nreq;
      imem_valid = 1'b1;
      imem_rdata = 16'hBEEF;
      @(posedge clk);
      #1 imem_valid = 1'b0;
      chk("late_rsp_ignored", instr, 16'h0000);
      do_instr(16'h0123, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      pin("after_reset_seq", 16'h0001);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multi-cycle instruction fetch and sequencing block for the 16-bit CPU.
- Owns the program counter and requests 16-bit words from instruction memory using a req/valid handshake.
- Presents the opcode and funct fields to the control unit.
- Consumes the control unit's branch/jump outputs plus the ALU zero flag to compute the next PC when the datapath retires an instruction.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles in WAIT before flagging a fetch error.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, one-cycle pulse
- imem_addr  out  16  word address of the fetch
- imem_valid  in  1  read data valid; ignored outside WAIT
- imem_rdata  in  16  instruction word
- instr_valid  out  1  held instruction is presented to the datapath
- instr  out  16  held instruction word
- opcode  out  4  instr[15:12]
- funct  out  4  instr[3:0]
- pc  out  16  address of the held instruction
- exec_done  in  1  datapath retires the held instruction this cycle
- branch  in  1  Branch from control unit
- jump  in  1  Jump from control unit
- alu_zero  in  1  ALU zero flag
- halted  out  1  HALT (opcode 4'b1111) retired
- fetch_err  out  1  sticky; WAIT exceeded TIMEOUT

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, pc=RESET_PC, instr=0.
  - All of instr_valid, imem_req, halted, fetch_err are 0; timeout counter=0.
- States: FETCH, WAIT, ISSUE, HALT, ERROR.
- FETCH:
  - imem_req=1 for exactly one cycle, imem_addr=pc; go to WAIT; counter cleared.
  - imem_addr equals pc in all states; it is only meaningful while imem_req=1.
- WAIT:
  - On imem_valid=1: latch imem_rdata into instr, go to ISSUE.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT with no valid, go to ERROR and set fetch_err.
  - Minimum latency: request in cycle N, data in N+1, instr_valid from N+2.
- ISSUE:
  - instr_valid=1; instr, opcode, funct and pc are stable until retirement.
  - On exec_done=1, retire. Next-PC rule, all arithmetic mod 2^16:
    - jump=1: pc <= {pc[15:12], instr[11:0]}.
    - else branch=1 and taken: pc <= pc + 1 + sext(instr[3:0]). Taken means alu_zero=1 when opcode=4'b0100, alu_zero=0 when opcode=4'b0101.
    - else: pc <= pc + 1.
  - jump has priority over branch if both are asserted.
  - After retirement, go to FETCH; instr_valid drops the cycle after exec_done.
  - If opcode=4'b1111 at retirement, go to HALT instead; pc is not updated.
- HALT: halted=1, instr_valid=0, no requests; exit only by reset.
- ERROR: fetch_err=1, instr_valid=0, no requests; exit only by reset.
- Wrap-around: pc=16'hFFFF with sequential next gives 16'h0000. Branch offsets wrap likewise.
- imem_valid outside WAIT (late or stray response) is ignored; instr is unchanged.
- exec_done outside ISSUE is ignored.
- Reset mid-WAIT: state returns to FETCH immediately; the late response arriving after reset release lands in FETCH and is ignored.
- The fetch unit produces no combinational path from exec_done to imem_req; the request always occurs in the FETCH cycle following retirement.

Test Plan:
- Reset then release, memory answers after 1 cycle: imem_req pulses with addr 0x0000; instr_valid=1 two cycles after the request with instr=imem_rdata; pc=0x0000.
- Sequential retire of 0x0123 at pc=0x0005: next imem_addr=0x0006. At pc=0xFFFF: next imem_addr=0x0000.
- Branch tests:
  - opcode 0100, instr=0x4F3E, branch=1, alu_zero=1 at pc=0x0010 -> next pc=0x000F (offset -2).
  - Same instruction with alu_zero=0 -> 0x0011.
  - opcode 0101 with alu_zero=0, offset +3 -> 0x0014.
- Jump tests:
  - instr=0x6ABC at pc=0x3005, jump=1 -> next pc=0x3ABC.
  - jump=1 and branch=1 together -> jump target wins.
- Memory never asserts imem_valid: fetch_err=1 after TIMEOUT=16 WAIT cycles; no further imem_req. Then assert rst_n=0 asynchronously mid-cycle: fetch_err=0 and state=FETCH before the next clock edge.
- HALT handling: retire instr=0xF000 -> halted=1, instr_valid=0, no imem_req for 50 cycles. Then a stray imem_valid and exec_done are ignored.
